gravity_lock_timer: RTL and testbench

- Parametrised successor to the fixed-table piece clock divider.
- Generates the per-level gravity tick and soft-drop tick for the active piece.
- Adds a lock-delay state machine: the piece locks a fixed time after it lands, and a bounded number of successful moves restart that delay.
- Sits between the game FSM (spawn, level, landed/moved flags) and the piece movement logic (consumes gravity_tick and lock_req).

---
 rtl/gravity_lock_timer.sv | 119 +++++++++++
 tb/tb_gravity_lock_timer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gravity_lock_timer.sv
// Gravity / soft-drop tick generator with a bounded-restart lock-delay FSM.
// Build option: define SOFT_DROP_LOCK_EN to let soft_drop force an immediate lock while grounded.
module gravity_lock_timer #(
  parameter int CNT_W           = 26,
  parameter int LEVEL_W         = 4,
  parameter int BASE_PERIOD     = 48000000,
  parameter int LEVEL_STEP      = 5000000,
  parameter int MIN_PERIOD      = 3000000,
  parameter int SOFT_PERIOD     = 700000,
  parameter int LOCK_DELAY      = 25000000,
  parameter int MAX_LOCK_RESETS = 15,
  parameter int RST_W           = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [LEVEL_W-1:0] level,
  input  logic               spawn,
  input  logic               soft_drop,
  input  logic               pause,
  input  logic               grounded,
  input  logic               moved,
  output logic               gravity_tick,
  output logic               lock_req,
  output logic               locking,
  output logic [RST_W-1:0]   resets_left
);

  localparam int PW = CNT_W + LEVEL_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FALLING = 2'd1;
  localparam logic [1:0] LOCKING = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] grav_cnt;
  logic [CNT_W-1:0] lock_cnt;
  logic [PW-1:0]    level_cut;
  logic [CNT_W-1:0] base_period;
  logic [CNT_W-1:0] act_period;
  logic             soft_lock;

  // The product is kept wide so high levels saturate instead of wrapping below MIN_PERIOD.
  always_comb begin
    level_cut = PW'(level) * PW'(LEVEL_STEP);
    if (level_cut >= PW'(BASE_PERIOD - MIN_PERIOD))
      base_period = CNT_W'(MIN_PERIOD);
    else
      base_period = CNT_W'(BASE_PERIOD) - level_cut[CNT_W-1:0];
    act_period = base_period;
    if (soft_drop && (base_period > CNT_W'(SOFT_PERIOD)))
      act_period = CNT_W'(SOFT_PERIOD);
  end

`ifdef SOFT_DROP_LOCK_EN
  assign soft_lock = soft_drop;
`else
  assign soft_lock = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      grav_cnt     <= '0;
      lock_cnt     <= '0;
      gravity_tick <= 1'b0;
      lock_req     <= 1'b0;
      resets_left  <= '0;
    end else begin
      // NOTE: pulses default low every cycle so each one lasts exactly one clock;
      // non-blocking assignments let later branches override this default safely.
      gravity_tick <= 1'b0;
      lock_req     <= 1'b0;
      if (spawn) begin
        state       <= FALLING;
        grav_cnt    <= '0;
        lock_cnt    <= '0;
        resets_left <= RST_W'(MAX_LOCK_RESETS);
      end else if (!pause) begin
        case (state)
          FALLING: begin
            if (grounded) begin
              state    <= LOCKING;
              lock_cnt <= '0;
              grav_cnt <= '0;
            end else if (grav_cnt >= act_period - CNT_W'(1)) begin
              // >= rather than == so a shortened period fires at once instead of wrapping.
              gravity_tick <= 1'b1;
              grav_cnt     <= '0;
            end else begin
              grav_cnt <= grav_cnt + CNT_W'(1);
            end
          end
          LOCKING: begin
            if (!grounded) begin
              state    <= FALLING;
              grav_cnt <= '0;
            end else if (soft_lock) begin
              lock_req <= 1'b1;
              state    <= IDLE;
            end else if (moved && (resets_left != '0)) begin
              lock_cnt    <= '0;
              resets_left <= resets_left - RST_W'(1);
            end else if (lock_cnt >= CNT_W'(LOCK_DELAY - 1)) begin
              lock_req <= 1'b1;
              state    <= IDLE;
            end else begin
              lock_cnt <= lock_cnt + CNT_W'(1);
            end
          end
          IDLE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign locking = (state == LOCKING);

endmodule

// File: tb/tb_gravity_lock_timer.sv
// Directed bench for gravity_lock_timer using the small test-plan parameter set.
// Expectations for the soft-drop lock case follow SOFT_DROP_LOCK_EN when it is defined.
module tb_gravity_lock_timer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] level;
  logic       spawn, soft_drop, pause, grounded, moved;
  logic       gravity_tick, lock_req, locking;
  logic [3:0] resets_left;

  int n_checks = 0;
  int n_errors = 0;
  int both_cnt = 0;
  int dbl_cnt  = 0;
  logic prev_g = 1'b0;
  logic prev_l = 1'b0;

  gravity_lock_timer #(
    .CNT_W(8), .LEVEL_W(4), .BASE_PERIOD(20), .LEVEL_STEP(4), .MIN_PERIOD(5),
    .SOFT_PERIOD(3), .LOCK_DELAY(6), .MAX_LOCK_RESETS(2), .RST_W(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .level(level), .spawn(spawn), .soft_drop(soft_drop),
    .pause(pause), .grounded(grounded), .moved(moved), .gravity_tick(gravity_tick),
    .lock_req(lock_req), .locking(locking), .resets_left(resets_left)
  );

  always #5 CLK = ~CLK;

  // Pulse-shape monitor: overlap and stretched pulses are counted and checked at the end.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (gravity_tick && lock_req) both_cnt++;
      if ((gravity_tick && prev_g) || (lock_req && prev_l)) dbl_cnt++;
    end
    prev_g = gravity_tick;
    prev_l = lock_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_spawn();
    spawn = 1'b1;
    adv(1);
    spawn = 1'b0;
  endtask

  // Advance n cycles; the chosen pulse must appear on cycle n and nothing else before it.
  task automatic expect_pulse(input string tag, input int n, input bit grav);
    int stray = 0;
    for (int i = 1; i <= n; i++) begin
      adv(1);
      if (i < n && (gravity_tick === 1'b1 || lock_req === 1'b1)) stray++;
      if (i == n && (grav ? lock_req : gravity_tick) === 1'b1) stray++;
    end
    check({tag, "_quiet"}, stray, 0);
    check({tag, "_pulse"}, grav ? gravity_tick : lock_req, 1);
  endtask

  task automatic quiet(input string tag, input int n);
    int stray = 0;
    for (int i = 0; i < n; i++) begin
      adv(1);
      if (gravity_tick === 1'b1 || lock_req === 1'b1) stray++;
    end
    check(tag, stray, 0);
  endtask

  initial begin
    RESET = 1'b1; level = '0; spawn = 1'b0; soft_drop = 1'b0;
    pause = 1'b0; grounded = 1'b0; moved = 1'b0;
    adv(2);
    check("rst_grav", gravity_tick, 0);
    check("rst_lock", lock_req, 0);
    check("rst_locking", locking, 0);
    check("rst_resets", resets_left, 0);
    RESET = 1'b0;
    quiet("idle_quiet", 30);

    // Level 0 free fall
    do_spawn();
    check("spawn_resets", resets_left, 2);
    check("spawn_locking", locking, 0);
    expect_pulse("l0_t20", 20, 1);
    expect_pulse("l0_t40", 20, 1);
    expect_pulse("l0_t60", 20, 1);

    // Level-derived periods, including saturation
    level = 4'd3;  do_spawn();
    expect_pulse("l3_a", 8, 1);
    expect_pulse("l3_b", 8, 1);
    level = 4'd4;  do_spawn();
    expect_pulse("l4_a", 5, 1);
    expect_pulse("l4_b", 5, 1);
    level = 4'd15; do_spawn();
    expect_pulse("l15_a", 5, 1);
    expect_pulse("l15_b", 5, 1);

    // Shortening the period mid-count fires on the next cycle
    level = 4'd0; do_spawn();
    quiet("mid_pre", 12);
    level = 4'd4;
    expect_pulse("mid_fire", 1, 1);
    expect_pulse("mid_p5a", 5, 1);
    expect_pulse("mid_p5b", 5, 1);

    // Soft drop
    level = 4'd0; soft_drop = 1'b1; do_spawn();
    expect_pulse("soft_a", 3, 1);
    expect_pulse("soft_b", 3, 1);
    soft_drop = 1'b0;
    expect_pulse("soft_rel", 20, 1);

    // Landing and plain lock delay
    do_spawn();
    quiet("land_pre", 9);
    grounded = 1'b1;
    adv(1);
    check("land_locking", locking, 1);
    expect_pulse("land_lock", 6, 0);
    check("land_idle", locking, 0);
    check("land_resets", resets_left, 2);
    quiet("land_after", 25);

    // Move restarts, bounded by MAX_LOCK_RESETS
    do_spawn();
    adv(1);
    check("mv_locking", locking, 1);
    adv(1);
    moved = 1'b1; adv(1); moved = 1'b0;
    check("mv_res1", resets_left, 1);
    adv(1);
    moved = 1'b1; adv(1); moved = 1'b0;
    check("mv_res0", resets_left, 0);
    adv(1);
    moved = 1'b1; adv(1); moved = 1'b0;
    check("mv_ignored", resets_left, 0);
    expect_pulse("mv_lock", 4, 0);

    // Pause in FALLING shifts the tick by the pause length
    grounded = 1'b0; do_spawn();
    quiet("pf_pre", 5);
    pause = 1'b1;
    quiet("pf_hold", 7);
    pause = 1'b0;
    expect_pulse("pf_tick", 15, 1);
    expect_pulse("pf_next", 20, 1);

    // Pause in LOCKING shifts the lock by the pause length
    grounded = 1'b1;
    adv(1);
    adv(2);
    pause = 1'b1;
    quiet("pl_hold", 7);
    check("pl_locking", locking, 1);
    pause = 1'b0;
    expect_pulse("pl_lock", 4, 0);

    // Asynchronous reset while locking
    do_spawn();
    adv(3);
    check("ar_pre_locking", locking, 1);
    RESET = 1'b1;
    #1;
    check("ar_locking", locking, 0);
    check("ar_resets", resets_left, 0);
    check("ar_grav", gravity_tick, 0);
    check("ar_lock", lock_req, 0);
    #2;
    RESET = 1'b0;
    quiet("ar_idle", 10);
    check("ar_idle_locking", locking, 0);

    // Spawn during LOCKING restarts the piece
    do_spawn();
    adv(1);
    moved = 1'b1; adv(1); moved = 1'b0;
    check("sp_res1", resets_left, 1);
    spawn = 1'b1; grounded = 1'b0;
    adv(1);
    spawn = 1'b0;
    check("sp_locking", locking, 0);
    check("sp_res2", resets_left, 2);
    expect_pulse("sp_tick", 20, 1);

    // Sliding off a ledge returns to FALLING and keeps resets_left
    grounded = 1'b1;
    adv(1);
    check("slide_locking", locking, 1);
    adv(2);
    grounded = 1'b0;
    adv(1);
    check("slide_falling", locking, 0);
    check("slide_res", resets_left, 2);
    expect_pulse("slide_tick", 20, 1);

    // Soft drop while locking
    grounded = 1'b1; do_spawn();
    adv(1);
    adv(1);
    soft_drop = 1'b1;
`ifdef SOFT_DROP_LOCK_EN
    expect_pulse("sdl_lock", 1, 0);
`else
    expect_pulse("sdl_lock", 5, 0);
`endif
    check("sdl_idle", locking, 0);
    soft_drop = 1'b0;
    grounded  = 1'b0;
    adv(2);

    check("never_both", both_cnt, 0);
    check("single_cycle", dbl_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
